// File: rtl/fxp_mean_square_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fxp_mean_square_pkg
// Brief   : Width helpers and saturation constant for the mean-square stage.
// Revision: 1.0 - initial release
// ============================================================================
package fxp_mean_square_pkg;

    // Saturation limit for the default 9.10 output format.
    localparam longint unsigned OUT_MAX = (64'd1 << (9 + 10 - 1)) - 64'd1;

    function automatic int sq_width(input int w);
        return 2 * w - 1;
    endfunction

    function automatic int acc_width(input int w, input int logn);
        return 2 * w - 1 + logn;
    endfunction

    function automatic int frac_shift(input int wif, input int wof);
        return 2 * wif - wof;
    endfunction

    function automatic longint unsigned out_max(input int woi, input int wof);
        return (64'd1 << (woi + wof - 1)) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fxp_square.sv
`default_nettype none
// ============================================================================
// Module  : pipe_fxp_square
// Brief   : Two-stage registered squarer of signed samples (input reg, square).
// Revision: 1.0 - initial release
// ============================================================================
module pipe_fxp_square
    import fxp_mean_square_pkg::*;
#(
    parameter int W = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     i_valid,
    input  logic signed [W-1:0]      i_data,
    output logic                     o_valid,
    output logic [sq_width(W)-1:0]   o_sq
);

    localparam int c_SQW = sq_width(W);

    logic signed [W-1:0] r_s1;
    logic                r_s1_valid;
    logic [W-1:0]        w_mag;
    logic [c_SQW-1:0]    w_sq;
    logic [c_SQW-1:0]    r_sq;
    logic                r_sq_valid;

    // Unsigned magnitude keeps -2**(W-1) exact: its square fits in 2W-1 bits.
    assign w_mag = r_s1[W-1] ? (~r_s1 + 1'b1) : r_s1;
    assign w_sq  = c_SQW'(w_mag) * c_SQW'(w_mag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
            r_sq       <= '0;
            r_sq_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_valid & ~clear;
            if (i_valid) begin
                r_s1 <= i_data;
            end
            r_sq_valid <= r_s1_valid & ~clear;
            r_sq       <= w_sq;
        end
    end

    assign o_valid = r_sq_valid;
    assign o_sq    = r_sq;

endmodule
`default_nettype wire

// File: rtl/pipe_fixed_point_mean_square.sv
`default_nettype none
// ============================================================================
// Module  : pipe_fixed_point_mean_square
// Brief   : Windowed mean square of a signed fixed-point stream, rounded and
//           saturated to WOI.WOF, with a one-cycle result strobe.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_fixed_point_mean_square
    import fxp_mean_square_pkg::*;
#(
    parameter int WII   = 9,
    parameter int WIF   = 10,
    parameter int WOI   = 9,
    parameter int WOF   = 10,
    parameter int LOGN  = 4,
    parameter int ROUND = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic signed [WII+WIF-1:0]   in,
    output logic                        out_valid,
    output logic [WOI+WOF-1:0]          out,
    output logic                        overflow
);

    localparam int c_W    = WII + WIF;
    localparam int c_SQW  = sq_width(c_W);
    localparam int c_ACCW = acc_width(c_W, LOGN);
    localparam int c_FS   = frac_shift(WIF, WOF);
    localparam int c_SHR  = (c_FS > 0) ? c_FS : 0;
    localparam int c_SHL  = (c_FS < 0) ? -c_FS : 0;
    localparam int c_OW   = WOI + WOF;
    localparam int c_XWA  = c_SQW + 1 + c_SHL;
    localparam int c_XW   = (c_XWA > c_OW) ? c_XWA : c_OW;

    localparam logic [LOGN-1:0] c_CNT_LAST = LOGN'((1 << LOGN) - 1);
    localparam logic [c_XW-1:0] c_OUT_MAX  = c_XW'(out_max(WOI, WOF));
    localparam logic [c_XW-1:0] c_HALF     = (ROUND != 0 && c_SHR > 0)
                                           ? (c_XW'(1) << ((c_SHR > 0) ? c_SHR - 1 : 0))
                                           : '0;

    logic               w_sq_valid;
    logic [c_SQW-1:0]   w_sq;
    logic [c_ACCW-1:0]  w_sum;
    logic [c_ACCW-1:0]  r_acc;
    logic [LOGN-1:0]    r_cnt;
    logic [c_ACCW-1:0]  r_total;
    logic               r_total_valid;
    logic [c_XW-1:0]    w_mean;
    logic [c_XW-1:0]    w_align;
    logic               w_sat;
    logic [c_OW-1:0]    w_res;
    logic               r_out_valid;
    logic [c_OW-1:0]    r_out;
    logic               r_overflow;

    pipe_fxp_square #(
        .W (c_W)
    ) u_square (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .i_valid (in_valid),
        .i_data  (in),
        .o_valid (w_sq_valid),
        .o_sq    (w_sq)
    );

    assign w_sum = r_acc + c_ACCW'(w_sq);

    // S3: window accumulator; the window's last sample hands the total to S4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_total       <= '0;
            r_total_valid <= 1'b0;
        end else if (clear) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_total_valid <= 1'b0;
        end else begin
            r_total_valid <= 1'b0;
            if (w_sq_valid) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_total       <= w_sum;
                    r_total_valid <= 1'b1;
                    r_acc         <= '0;
                    r_cnt         <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Mean always fits in 2W-1 bits, so narrowing after the divide loses nothing.
    assign w_mean  = c_XW'(r_total >> LOGN);
    assign w_align = ((w_mean + c_HALF) >> c_SHR) << c_SHL;
    assign w_sat   = (w_align > c_OUT_MAX);
    assign w_res   = w_sat ? c_OUT_MAX[c_OW-1:0] : w_align[c_OW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_overflow  <= 1'b0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_total_valid;
            if (r_total_valid) begin
                r_out      <= w_res;
                r_overflow <= w_sat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fixed_point_mean_square.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_fixed_point_mean_square
// Brief   : Directed bench for the windowed mean-square stage (N = 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_fixed_point_mean_square;

    localparam int LOGN = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clear = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [18:0] in = '0;
    logic               out_valid, overflow;
    logic [18:0]        out;
    logic               t_out_valid, t_overflow;
    logic [18:0]        t_out;

    pipe_fixed_point_mean_square #(.LOGN(LOGN), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(in),
        .out_valid(out_valid), .out(out), .overflow(overflow)
    );

    pipe_fixed_point_mean_square #(.LOGN(LOGN), .ROUND(0)) dut_trunc (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(in),
        .out_valid(t_out_valid), .out(t_out), .overflow(t_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int          q_cyc[$];
    logic [18:0] q_out[$];
    logic        q_ovf[$];
    logic [18:0] q_tr[$];
    logic        q_tv[$];

    always @(negedge clk) begin
        if (out_valid) begin
            q_cyc.push_back(cyc);
            q_out.push_back(out);
            q_ovf.push_back(overflow);
            q_tr.push_back(t_out);
            q_tv.push_back(t_out_valid);
        end
    end

    int n_checks  = 0;
    int n_pass    = 0;
    int last_edge = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send(input logic v, input logic signed [18:0] d, input logic c);
        @(negedge clk);
        in_valid = v;
        in       = d;
        clear    = c;
        if (v && !c) last_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, '0, 1'b0);
    endtask

    task automatic window4(input logic signed [18:0] d);
        repeat (4) send(1'b1, d, 1'b0);
    endtask

    task automatic clr_q();
        q_cyc.delete(); q_out.delete(); q_ovf.delete(); q_tr.delete(); q_tv.delete();
    endtask

    task automatic check_one(input string tag, input logic [18:0] eo, input logic eovf);
        idle(6);
        check({tag, "_count"}, q_cyc.size(), 1);
        if (q_cyc.size() >= 1) begin
            check({tag, "_latency"}, q_cyc[0], last_edge + 3);
            check({tag, "_out"}, q_out[0], eo);
            check({tag, "_ovf"}, q_ovf[0], eovf);
        end
        check({tag, "_hold"}, out, eo);
        check({tag, "_strobe_low"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_valid", out_valid, 0);
        rst = 1'b1;
        idle(2);

        // 1: 2.0^2 = 4.0
        clr_q(); window4(19'sd2048);
        check_one("t1", 19'd4096, 1'b0);

        // 2: alternating signs of 3.0 -> 9.0
        clr_q();
        send(1'b1, -19'sd3072, 1'b0); send(1'b1, 19'sd3072, 1'b0);
        send(1'b1, -19'sd3072, 1'b0); send(1'b1, 19'sd3072, 1'b0);
        check_one("t2", 19'd9216, 1'b0);

        // 3: saturation, then recovery
        clr_q(); window4(19'sh3FFFF);
        check_one("t3_sat", 19'h3FFFF, 1'b1);
        clr_q(); window4(19'sd1024);
        check_one("t3_one", 19'd1024, 1'b0);

        // 4: 529/1024 LSB rounds to 1, truncates to 0
        clr_q(); window4(19'sd23);
        check_one("t4_round", 19'd1, 1'b0);
        if (q_tr.size() >= 1) begin
            check("t4_trunc_out", q_tr[0], 0);
            check("t4_trunc_valid", q_tv[0], 1);
        end
        check("t4_trunc_ovf", t_overflow, 0);

        // 5a: gaps in in_valid
        clr_q();
        send(1'b1, 19'sd1024, 1'b0); send(1'b0, 19'sd1024, 1'b0);
        send(1'b0, 19'sd1024, 1'b0); send(1'b1, 19'sd1024, 1'b0);
        send(1'b1, 19'sd1024, 1'b0); send(1'b0, 19'sd1024, 1'b0);
        send(1'b1, 19'sd1024, 1'b0);
        check_one("t5_gaps", 19'd1024, 1'b0);

        // 5b: back-to-back windows
        clr_q(); window4(19'sd1024); window4(19'sd2048);
        idle(6);
        check("t5_b2b_count", q_cyc.size(), 2);
        if (q_cyc.size() >= 2) begin
            check("t5_b2b_spacing", q_cyc[1] - q_cyc[0], 4);
            check("t5_b2b_out0", q_out[0], 1024);
            check("t5_b2b_out1", q_out[1], 4096);
            check("t5_b2b_latency", q_cyc[1], last_edge + 3);
        end

        // 5c: clear discards partial window and the sample presented with it
        clr_q();
        send(1'b1, 19'sd5120, 1'b0); send(1'b1, 19'sd5120, 1'b0);
        send(1'b1, 19'sd5120, 1'b1);
        window4(19'sd1024);
        check_one("t5_clear", 19'd1024, 1'b0);

        // 6a: async reset mid-window while overflow is set
        clr_q(); window4(19'sh3FFFF);
        check_one("t6_presat", 19'h3FFFF, 1'b1);
        clr_q();
        send(1'b1, 19'sd3072, 1'b0); send(1'b1, 19'sd3072, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("t6a_async_out", out, 0);
        check("t6a_async_ovf", overflow, 0);
        check("t6a_async_valid", out_valid, 0);
        idle(2);
        rst = 1'b1;
        window4(19'sd2048);
        check_one("t6a_after", 19'd4096, 1'b0);

        // 6b: async reset while a total sits in S3 awaiting conversion
        clr_q(); window4(19'sd3072);
        idle(3);
        #2 rst = 1'b0;
        #1;
        check("t6b_async_out", out, 0);
        check("t6b_async_valid", out_valid, 0);
        idle(2);
        rst = 1'b1;
        idle(6);
        check("t6b_no_leak", q_cyc.size(), 0);
        clr_q(); window4(19'sd2048);
        check_one("t6b_after", 19'd4096, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
